// File: rtl/l1_vp_trans_arb_rr_pkg.sv
// Shared constants and helpers for the translation-request arbiter.
package l1_vp_trans_arb_rr_pkg;

    localparam logic [1:0] PRV_U   = 2'd0;
    localparam logic [1:0] PRV_S   = 2'd1;
    localparam logic [1:0] PRV_M   = 2'd3;
    localparam logic [4:0] VM_SV39 = 5'd9;

    // Index width for n entries, never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/l1_vp_trans_arb_rr_if.sv
// Request/response bus of the translation arbiter.
// Ports: per-channel req valid/ready/instruction/passthrough/vpn,
//        single resp valid/ready with granted port, vpn, priv, priv_s, vm_enabled.
// master = requesters + response consumer, slave = arbiter.
interface l1_vp_trans_arb_rr_if
    import l1_vp_trans_arb_rr_pkg::*;
#(
    parameter int unsigned NPORTS = 2,
    parameter int unsigned VPN_W  = 27
);
    localparam int unsigned PW = clog2(NPORTS);

    logic [NPORTS-1:0]       io_req_valid;
    logic [NPORTS-1:0]       io_req_ready;
    logic [NPORTS-1:0]       io_req_bits_instruction;
    logic [NPORTS-1:0]       io_req_bits_passthrough;
    logic [NPORTS*VPN_W-1:0] io_req_bits_vpn;

    logic                    io_resp_valid;
    logic                    io_resp_ready;
    logic [PW-1:0]           io_resp_port;
    logic [VPN_W-1:0]        io_resp_vpn;
    logic [1:0]              io_resp_priv;
    logic                    io_resp_priv_s;
    logic                    io_resp_vm_enabled;

    modport master (
        output io_req_valid, io_req_bits_instruction, io_req_bits_passthrough,
               io_req_bits_vpn, io_resp_ready,
        input  io_req_ready, io_resp_valid, io_resp_port, io_resp_vpn,
               io_resp_priv, io_resp_priv_s, io_resp_vm_enabled
    );

    modport slave (
        input  io_req_valid, io_req_bits_instruction, io_req_bits_passthrough,
               io_req_bits_vpn, io_resp_ready,
        output io_req_ready, io_resp_valid, io_resp_port, io_resp_vpn,
               io_resp_priv, io_resp_priv_s, io_resp_vm_enabled
    );
endinterface

// File: rtl/l1_priv_decode.sv
// Effective privilege and translation-enable decode for one channel.
// Ports: status fields (mprv, mpp, prv, debug, vm), channel instruction and
//        passthrough flags; combinational priv_c, priv_s_c, vm_enabled_c.
module l1_priv_decode
    import l1_vp_trans_arb_rr_pkg::*;
#(
    parameter logic [4:0] VM_MODE = VM_SV39
) (
    input  logic       mprv,
    input  logic [1:0] mpp,
    input  logic [1:0] prv,
    input  logic       debug,
    input  logic [4:0] vm,
    input  logic       instruction,
    input  logic       passthrough,
    output logic [1:0] priv_c,
    output logic       priv_s_c,
    output logic       vm_enabled_c
);
    // MPRV only redirects data accesses, never fetches.
    logic do_mprv;

    assign do_mprv      = mprv & ~instruction;
    assign priv_c       = do_mprv ? mpp : prv;
    assign priv_s_c     = (priv_c == PRV_S);
    assign vm_enabled_c = (vm == VM_MODE) && (priv_c <= PRV_S) && !debug && !passthrough;
endmodule

// File: rtl/l1_vp_trans_arb_rr.sv
// Round-robin arbiter feeding a one-deep translation request register.
// Ports: clk, reset_n (async active-low), status inputs, io_flush,
//        bus (slave side of l1_vp_trans_arb_rr_if).
module l1_vp_trans_arb_rr
    import l1_vp_trans_arb_rr_pkg::*;
#(
    parameter int unsigned NPORTS  = 2,
    parameter int unsigned VPN_W   = 27,
    parameter logic [4:0]  VM_MODE = 5'd9
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       io_ptw_status_mprv,
    input  logic [1:0] io_ptw_status_mpp,
    input  logic [1:0] io_ptw_status_prv,
    input  logic       io_ptw_status_debug,
    input  logic [4:0] io_ptw_status_vm,
    input  logic       io_flush,
    l1_vp_trans_arb_rr_if.slave bus
);
    localparam int unsigned PW = clog2(NPORTS);

    logic [NPORTS-1:0][1:0] priv_c;
    logic [NPORTS-1:0]      priv_s_c;
    logic [NPORTS-1:0]      vm_enabled_c;

    logic [PW-1:0]    rr_ptr;
    logic             resp_valid;
    logic [PW-1:0]    resp_port;
    logic [VPN_W-1:0] resp_vpn;
    logic [1:0]       resp_priv;
    logic             resp_priv_s;
    logic             resp_vm_enabled;

    logic             found_c;
    logic [PW-1:0]    grant_idx_c;
    logic             accept_c;
    logic [PW-1:0]    next_ptr_c;

    // Per-channel privilege decode from the live status.
    for (genvar i = 0; i < NPORTS; i++) begin : g_dec
        l1_priv_decode #(.VM_MODE(VM_MODE)) u_dec (
            .mprv         (io_ptw_status_mprv),
            .mpp          (io_ptw_status_mpp),
            .prv          (io_ptw_status_prv),
            .debug        (io_ptw_status_debug),
            .vm           (io_ptw_status_vm),
            .instruction  (bus.io_req_bits_instruction[i]),
            .passthrough  (bus.io_req_bits_passthrough[i]),
            .priv_c       (priv_c[i]),
            .priv_s_c     (priv_s_c[i]),
            .vm_enabled_c (vm_enabled_c[i])
        );
    end

    // First valid channel at or after rr_ptr, wrapping.
    always_comb begin
        found_c     = 1'b0;
        grant_idx_c = '0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            if (!found_c && bus.io_req_valid[PW'((32'(rr_ptr) + k) % NPORTS)]) begin
                found_c     = 1'b1;
                grant_idx_c = PW'((32'(rr_ptr) + k) % NPORTS);
            end
        end
    end

    // Accept only when the stage can take a new result and no flush is in progress.
    always_comb begin
        accept_c = found_c && !io_flush && (!resp_valid || bus.io_resp_ready);
        bus.io_req_ready = '0;
        if (accept_c) begin
            bus.io_req_ready[grant_idx_c] = 1'b1;
        end
        next_ptr_c = (grant_idx_c == PW'(NPORTS - 1)) ? '0 : grant_idx_c + 1'b1;
    end

    // Result register and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr          <= '0;
            resp_valid      <= 1'b0;
            resp_port       <= '0;
            resp_vpn        <= '0;
            resp_priv       <= '0;
            resp_priv_s     <= 1'b0;
            resp_vm_enabled <= 1'b0;
        end else if (io_flush) begin
            resp_valid <= 1'b0;
        end else if (accept_c) begin
            rr_ptr          <= next_ptr_c;
            resp_valid      <= 1'b1;
            resp_port       <= grant_idx_c;
            resp_vpn        <= bus.io_req_bits_vpn[32'(grant_idx_c) * VPN_W +: VPN_W];
            resp_priv       <= priv_c[grant_idx_c];
            resp_priv_s     <= priv_s_c[grant_idx_c];
            resp_vm_enabled <= vm_enabled_c[grant_idx_c];
        end else if (bus.io_resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    assign bus.io_resp_valid      = resp_valid;
    assign bus.io_resp_port       = resp_port;
    assign bus.io_resp_vpn        = resp_vpn;
    assign bus.io_resp_priv       = resp_priv;
    assign bus.io_resp_priv_s     = resp_priv_s;
    assign bus.io_resp_vm_enabled = resp_vm_enabled;
endmodule

// File: tb/tb_l1_vp_trans_arb_rr.sv
// Directed bench for l1_vp_trans_arb_rr with a per-cycle reference model.
module tb_l1_vp_trans_arb_rr;
    localparam int unsigned N  = 2;
    localparam int unsigned VW = 27;

    logic       clk;
    logic       reset_n;
    logic       mprv;
    logic [1:0] mpp;
    logic [1:0] prv;
    logic       debug;
    logic [4:0] vm;
    logic       flush;

    int checks;
    int failures;

    // Reference state: the single held response and the fairness pointer.
    logic          m_valid;
    int            m_port;
    logic [VW-1:0] m_vpn;
    logic [1:0]    m_priv;
    logic          m_priv_s;
    logic          m_vm;
    int            m_ptr;

    l1_vp_trans_arb_rr_if #(.NPORTS(N), .VPN_W(VW)) bus ();

    l1_vp_trans_arb_rr #(.NPORTS(N), .VPN_W(VW), .VM_MODE(5'd9)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .io_ptw_status_mprv  (mprv),
        .io_ptw_status_mpp   (mpp),
        .io_ptw_status_prv   (prv),
        .io_ptw_status_debug (debug),
        .io_ptw_status_vm    (vm),
        .io_flush            (flush),
        .bus                 (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Which channel should be accepted right now, as a one-hot vector.
    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        r = '0;
        if (!flush && (!m_valid || bus.io_resp_ready)) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (r == '0 && bus.io_req_valid[c]) r[c] = 1'b1;
            end
        end
        return r;
    endfunction

    // Reference model advance on each clock edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid = 1'b0; m_port = 0; m_vpn = '0;
            m_priv = 2'd0; m_priv_s = 1'b0; m_vm = 1'b0; m_ptr = 0;
        end else begin
            logic [N-1:0] r;
            r = exp_ready();
            if (r != '0) begin
                int g;
                logic [1:0] p;
                g = r[0] ? 0 : 1;
                p = (mprv && !bus.io_req_bits_instruction[g]) ? mpp : prv;
                m_valid  = 1'b1;
                m_port   = g;
                m_vpn    = bus.io_req_bits_vpn[g*VW +: VW];
                m_priv   = p;
                m_priv_s = (p == 2'd1);
                m_vm     = (vm == 5'd9) && (p <= 2'd1) && !debug && !bus.io_req_bits_passthrough[g];
                m_ptr    = (g + 1) % N;
            end else if (flush || bus.io_resp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            check("req_ready", 64'(bus.io_req_ready), 64'(exp_ready()));
            check("resp_valid", 64'(bus.io_resp_valid), 64'(m_valid));
            if (m_valid) begin
                check("resp_port", 64'(bus.io_resp_port), 64'(m_port));
                check("resp_vpn", 64'(bus.io_resp_vpn), 64'(m_vpn));
                check("resp_priv", 64'(bus.io_resp_priv), 64'(m_priv));
                check("resp_priv_s", 64'(bus.io_resp_priv_s), 64'(m_priv_s));
                check("resp_vm_enabled", 64'(bus.io_resp_vm_enabled), 64'(m_vm));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_port [4];
        exp_port[0] = 0; exp_port[1] = 1; exp_port[2] = 0; exp_port[3] = 1;
        checks = 0; failures = 0;
        reset_n = 1'b0;
        mprv = 1'b0; mpp = 2'd0; prv = 2'd1; debug = 1'b0; vm = 5'd9; flush = 1'b0;
        bus.io_req_valid = '0;
        bus.io_req_bits_instruction = '0;
        bus.io_req_bits_passthrough = '0;
        bus.io_req_bits_vpn = {27'h0456, 27'h0123};
        bus.io_resp_ready = 1'b1;
        #2;
        check("rst_valid", 64'(bus.io_resp_valid), 64'd0);
        check("rst_port", 64'(bus.io_resp_port), 64'd0);
        check("rst_vpn", 64'(bus.io_resp_vpn), 64'd0);
        check("rst_priv", 64'(bus.io_resp_priv), 64'd0);
        check("rst_vm", 64'(bus.io_resp_vm_enabled), 64'd0);
        repeat (2) tick();
        reset_n = 1'b1;

        // Alternating grants with both channels requesting.
        bus.io_req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_port", 64'(bus.io_resp_port), 64'(exp_port[i]));
            check("rr_valid", 64'(bus.io_resp_valid), 64'd1);
            check("rr_priv_s", 64'(bus.io_resp_priv_s), 64'd1);
            check("rr_vm", 64'(bus.io_resp_vm_enabled), 64'd1);
        end
        bus.io_req_valid = 2'b00;
        tick();
        check("drain_valid", 64'(bus.io_resp_valid), 64'd0);

        // MPRV applies to data accesses only.
        mprv = 1'b1; mpp = 2'd0; prv = 2'd3;
        bus.io_req_valid = 2'b01;
        tick();
        check("mprv_data_priv", 64'(bus.io_resp_priv), 64'd0);
        check("mprv_data_priv_s", 64'(bus.io_resp_priv_s), 64'd0);
        check("mprv_data_vm", 64'(bus.io_resp_vm_enabled), 64'd1);
        bus.io_req_bits_instruction = 2'b01;
        tick();
        check("mprv_fetch_priv", 64'(bus.io_resp_priv), 64'd3);
        check("mprv_fetch_vm", 64'(bus.io_resp_vm_enabled), 64'd0);
        bus.io_req_bits_instruction = 2'b00;
        bus.io_req_valid = 2'b00;
        mprv = 1'b0;
        tick();

        // Backpressure: held result is immune to status changes.
        prv = 2'd1;
        bus.io_req_valid = 2'b01;
        bus.io_resp_ready = 1'b0;
        tick();
        prv = 2'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_priv", 64'(bus.io_resp_priv), 64'd1);
            check("hold_valid", 64'(bus.io_resp_valid), 64'd1);
            check("hold_ready", 64'(bus.io_req_ready), 64'd0);
        end
        bus.io_req_valid = 2'b00;
        bus.io_resp_ready = 1'b1;
        tick();
        check("hold_release", 64'(bus.io_resp_valid), 64'd0);

        // Conditions that disable translation at user level.
        prv = 2'd0;
        bus.io_req_valid = 2'b01;
        debug = 1'b1;
        tick();
        check("dbg_vm", 64'(bus.io_resp_vm_enabled), 64'd0);
        check("dbg_priv_s", 64'(bus.io_resp_priv_s), 64'd0);
        debug = 1'b0;
        bus.io_req_bits_passthrough = 2'b01;
        tick();
        check("pass_vm", 64'(bus.io_resp_vm_enabled), 64'd0);
        bus.io_req_bits_passthrough = 2'b00;
        vm = 5'd0;
        tick();
        check("bare_vm", 64'(bus.io_resp_vm_enabled), 64'd0);
        vm = 5'd9;
        tick();
        check("user_vm", 64'(bus.io_resp_vm_enabled), 64'd1);

        // Flush drops the held result and blocks accepts for that cycle.
        bus.io_resp_ready = 1'b0;
        tick();
        flush = 1'b1;
        bus.io_resp_ready = 1'b1;
        #1;
        check("flush_block", 64'(bus.io_req_ready), 64'd0);
        tick();
        check("flush_valid", 64'(bus.io_resp_valid), 64'd0);
        flush = 1'b0;
        #1;
        check("post_flush_ready", 64'(bus.io_req_ready), 64'd1);
        tick();
        check("post_flush_valid", 64'(bus.io_resp_valid), 64'd1);

        // Reset in the middle of traffic.
        bus.io_req_valid = 2'b11;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_valid", 64'(bus.io_resp_valid), 64'd0);
        check("midrst_port", 64'(bus.io_resp_port), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        check("after_rst_port", 64'(bus.io_resp_port), 64'd0);
        check("after_rst_valid", 64'(bus.io_resp_valid), 64'd1);
        tick();
        check("after_rst_port2", 64'(bus.io_resp_port), 64'd1);
        bus.io_req_valid = 2'b00;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/l1_vp_trans_arb_rr.md
L1_VP_TRANS_ARB_RR -- requirements
Module: l1_vp_trans_arb_rr

Interface
REQ-001 SHALL have parameter NPORTS, default 2, number of requesting channels (1..8).
REQ-002 SHALL have parameter VPN_W, default 27, virtual page number width.
REQ-003 SHALL have parameter VM_MODE, default 5'd9, status.vm encoding that enables translation.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 io_req_valid  input  NPORTS  per-channel request valid.
REQ-007 io_req_ready  output  NPORTS  per-channel accept.
REQ-008 io_req_bits_instruction  input  NPORTS  1 = fetch request, per channel.
REQ-009 io_req_bits_passthrough  input  NPORTS  1 = bypass translation, per channel.
REQ-010 io_req_bits_vpn  input  NPORTS*VPN_W  channel i occupies bits [i*VPN_W +: VPN_W].
REQ-011 io_ptw_status_mprv  input  1;  io_ptw_status_mpp  input  2;  io_ptw_status_prv  input  2;  io_ptw_status_debug  input  1;  io_ptw_status_vm  input  5.
REQ-012 io_flush  input  1  drops the held result (sfence/context switch).
REQ-013 io_resp_valid  output  1;  io_resp_ready  input  1.
REQ-014 io_resp_port  output  clog2(NPORTS), min 1  granted channel index.
REQ-015 io_resp_vpn  output  VPN_W;  io_resp_priv  output  2;  io_resp_priv_s  output  1;  io_resp_vm_enabled  output  1.

Function
REQ-016 Per channel: do_mprv = mprv AND NOT instruction; priv = do_mprv ? mpp : prv.
REQ-017 priv_s SHALL be (priv == 1).
REQ-018 vm_enabled SHALL be (vm == VM_MODE) AND (priv <= 1) AND NOT debug AND NOT passthrough.
REQ-019 Round-robin pointer rr_ptr: search starts at rr_ptr, wraps modulo NPORTS; first valid channel wins.
REQ-020 Stage free = NOT io_resp_valid OR io_resp_ready; io_req_ready[i] = free AND grant[i]; at most one ready bit high per cycle.
REQ-021 On accept, result register SHALL load port, vpn, priv, priv_s, vm_enabled, using status sampled that cycle; io_resp_valid set next cycle (latency 1).
REQ-022 After an accept on channel g, rr_ptr SHALL become (g+1) mod NPORTS; unchanged if nothing accepted.
REQ-023 Simultaneous response handshake and new accept SHALL reload the register with no bubble (full throughput).
REQ-024 Outputs SHALL hold stable while io_resp_valid AND NOT io_resp_ready.
REQ-025 io_flush SHALL clear io_resp_valid next cycle and block any accept in the flush cycle; rr_ptr unchanged.
REQ-026 Status changes while a result is held SHALL NOT alter the held result.
REQ-027 No valid requests: io_req_ready all 0, state unchanged.

Reset
REQ-028 Asserting reset_n low SHALL immediately clear io_resp_valid, rr_ptr to 0, and resp_port/vpn/priv/priv_s/vm_enabled to 0, including mid-transaction.
REQ-029 First accept is allowed on the first rising edge after reset_n deasserts.

Structure
REQ-030 Shared package SHALL hold PRV_U=0, PRV_S=1, PRV_M=3, VM_SV39=5'd9, and the clog2 helper.
REQ-031 Privilege/vm_enabled decode SHALL be one sub-module, l1_priv_decode, instantiated NPORTS times; arbiter and register stay in the top.

Verification
REQ-032 NPORTS=2, both valid, prv=1, vm=9, resp_ready=1 -> grants 0,1,0,1 alternate; each response priv_s=1, vm_enabled=1.
REQ-033 Channel 0 data, mprv=1, mpp=0, prv=3, instruction=0 -> priv=0, priv_s=0, vm_enabled=1; same with instruction=1 -> priv=3, vm_enabled=0.
REQ-034 resp_ready=0 for 3 cycles with result held, prv changes 1->3 -> outputs unchanged, io_req_ready all 0, then one transfer when ready=1.
REQ-035 debug=1 or passthrough=1 or vm=0 with prv=0 -> vm_enabled=0, priv_s=0.
REQ-036 io_flush with held result and pending request -> resp_valid 0 next cycle, no accept that cycle, request accepted the following cycle.
REQ-037 reset_n low mid-stream with resp_valid=1 -> resp_valid 0 immediately, rr_ptr 0; after release, channel 0 granted first.
